// File: rtl/mod_counter.sv
// Modulo-N up-counter with enable; wrap pulses combinationally on the enabled
// cycle that takes the count from N-1 back to 0.
module mod_counter #(
    parameter int N = 8,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap
);

    logic [CW-1:0] count_r;
    logic          at_top_s;

    // Terminal-count decode and wrap strobe
    always_comb begin
        at_top_s = (count_r == CW'(N - 1));
        wrap     = en & at_top_s;
    end

    // Count register: advance on en, return to zero after N-1
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (en) begin
            if (at_top_s) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end
    end

    assign count = count_r;

endmodule

// File: rtl/serial_deserializer.sv
// Packs WIDTH enabled serial bits into a word and offers it through a
// one-entry valid/ready buffer; a word completing into a full buffer is dropped.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CW-1:0]    bit_count,
    output logic             overflow
);

    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] word_r;
    logic             valid_r;
    logic             overflow_r;
    logic             wrap_s;
    logic             accept_s;
    logic             load_s;
    logic             drop_s;

    mod_counter #(.N(WIDTH)) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (bit_count),
        .wrap  (wrap_s)
    );

    // Next shift value and buffer load/drop decisions
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_next_s = {shift_r[WIDTH-2:0], d};
        end else begin
            shift_next_s = {d, shift_r[WIDTH-1:1]};
        end
        accept_s = valid_r & word_ready;
        // An accept on the same edge frees the buffer, so completion never bubbles
        load_s   = wrap_s & (~valid_r | word_ready);
        drop_s   = wrap_s & valid_r & ~word_ready;
    end

    // Shift register, output buffer, handshake and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= {WIDTH{1'b0}};
            word_r     <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (en) begin
                shift_r <= shift_next_s;
            end
            if (load_s) begin
                word_r  <= shift_next_s;
                valid_r <= 1'b1;
            end else if (accept_s) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign word_out   = word_r;
    assign word_valid = valid_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one bit stream;
// expected words are queued at stimulus time and popped on each accept.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       d = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_m, word_l;
    logic       valid_m, valid_l;
    logic [2:0] cnt_m, cnt_l;
    logic       ovf_m, ovf_l;

    int checks = 0;
    int errors = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    bit   count_pulses = 1'b0;
    int   pulses = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .en(en), .d(d), .word_out(word_m),
        .word_valid(valid_m), .word_ready(word_ready), .bit_count(cnt_m),
        .overflow(ovf_m));

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .en(en), .d(d), .word_out(word_l),
        .word_valid(valid_l), .word_ready(word_ready), .bit_count(cnt_l),
        .overflow(ovf_l));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on every accepted word compare against the scoreboard head
    always @(negedge clk) begin
        if (!rst && valid_m && word_ready) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL msb_word: got %0h expected none", word_m);
            end else begin
                logic [7:0] e;
                e = q_m.pop_front();
                if (word_m !== e) begin
                    errors++;
                    $display("FAIL msb_word: got %0h expected %0h", word_m, e);
                end
            end
        end
        if (!rst && valid_l && word_ready) begin
            checks++;
            if (q_l.size() == 0) begin
                errors++;
                $display("FAIL lsb_word: got %0h expected none", word_l);
            end else begin
                logic [7:0] e;
                e = q_l.pop_front();
                if (word_l !== e) begin
                    errors++;
                    $display("FAIL lsb_word: got %0h expected %0h", word_l, e);
                end
            end
        end
        if (count_pulses && valid_m) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            en = 1'b1;
            d  = w[i];
            tick();
        end
        en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state
        word_ready = 1'b0;
        do_reset();
        check("rst_word", {24'd0, word_m}, 32'd0);
        check("rst_valid", {31'd0, valid_m}, 32'd0);
        check("rst_count", {29'd0, cnt_m}, 32'd0);
        check("rst_ovf", {31'd0, ovf_m}, 32'd0);

        // 2/3: 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
        q_m.push_back(8'hB2);
        q_l.push_back(8'h4D);
        for (int i = 0; i < 7; i++) begin
            en = 1'b1;
            d  = (i == 0 || i == 2 || i == 3 || i == 6);
            tick();
            check("no_early_valid", {31'd0, valid_m}, 32'd0);
        end
        en = 1'b1;
        d  = 1'b0;
        tick();
        en = 1'b0;
        check("valid_after_8", {31'd0, valid_m}, 32'd1);
        check("lsb_valid_after_8", {31'd0, valid_l}, 32'd1);
        check("count_wrap", {29'd0, cnt_m}, 32'd0);
        tick();
        check("held_word", {24'd0, word_m}, 32'h0000_00B2);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("drain_valid", {31'd0, valid_m}, 32'd0);
        check("drain_valid_l", {31'd0, valid_l}, 32'd0);

        // 4: en toggling, bit_count holds while en=0
        word_ready = 1'b1;
        q_m.push_back(8'hFF);
        q_l.push_back(8'hFF);
        for (int k = 1; k <= 8; k++) begin
            en = 1'b1;
            d  = 1'b1;
            tick();
            check("toggle_count_en", {29'd0, cnt_m}, 32'(k % 8));
            en = 1'b0;
            tick();
            check("toggle_count_hold", {29'd0, cnt_m}, 32'(k % 8));
        end
        check("toggle_ovf", {31'd0, ovf_m}, 32'd0);
        tick();
        check("toggle_drained", {31'd0, valid_m}, 32'd0);

        // 5: overflow with buffer full
        word_ready = 1'b0;
        q_m.push_back(8'hA5);
        q_l.push_back(8'hA5);
        send_word(8'hA5);
        check("ovf_after_1st", {31'd0, ovf_m}, 32'd0);
        send_word(8'h3C);
        check("ovf_set", {31'd0, ovf_m}, 32'd1);
        check("ovf_set_l", {31'd0, ovf_l}, 32'd1);
        check("ovf_word_kept", {24'd0, word_m}, 32'h0000_00A5);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("ovf_drain_valid", {31'd0, valid_m}, 32'd0);
        check("ovf_sticky", {31'd0, ovf_m}, 32'd1);

        // 6: continuous stream with ready high, then reset mid-word
        do_reset();
        check("ovf_cleared", {31'd0, ovf_m}, 32'd0);
        word_ready = 1'b1;
        q_m.push_back(8'h12); q_l.push_back(8'h48);
        q_m.push_back(8'h34); q_l.push_back(8'h2C);
        q_m.push_back(8'h56); q_l.push_back(8'h6A);
        count_pulses = 1'b1;
        send_word(8'h12);
        send_word(8'h34);
        send_word(8'h56);
        tick();
        tick();
        count_pulses = 1'b0;
        check("stream_pulses", 32'(pulses), 32'd3);
        check("stream_ovf", {31'd0, ovf_m}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            en = 1'b1;
            d  = 1'b1;
            tick();
        end
        en = 1'b0;
        check("partial_count", {29'd0, cnt_m}, 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", {29'd0, cnt_m}, 32'd0);
        pulses = 0;
        count_pulses = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        count_pulses = 1'b0;
        check("mid_rst_no_word", 32'(pulses), 32'd0);
        check("queue_m_empty", 32'(q_m.size()), 32'd0);
        check("queue_l_empty", 32'(q_l.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
